// File: rtl/ps2_kb_pkg.sv
// PS/2 keyboard shared definitions: protocol bytes,
// decoder states and the default ZX Spectrum 8x5 layout.
package ps2_kb_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;
  localparam logic [7:0] PS2_FE = 8'hFE;
  localparam int PAUSE_SKIP = 7;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK,
    DEC_PAUSE
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } km_t;

  function automatic km_t km_ent(input int r, input int c);
    km_t k;
    k.hit = 1'b1;
    k.row = 3'(r);
    k.col = 3'(c);
    return k;
  endfunction

  // Bytes that mean "keyboard reset or lost sync": drop every held key.
  function automatic logic is_clear(input logic [7:0] b);
    return b inside {PS2_AA, PS2_FA, PS2_FE, 8'h00, 8'hFF};
  endfunction

  function automatic km_t zx_keymap(input logic [7:0] code);
    km_t k;
    k = '0;
    case (code)
      8'h12: k = km_ent(0, 0);
      8'h1A: k = km_ent(0, 1);
      8'h22: k = km_ent(0, 2);
      8'h21: k = km_ent(0, 3);
      8'h2A: k = km_ent(0, 4);
      8'h1C: k = km_ent(1, 0);
      8'h1B: k = km_ent(1, 1);
      8'h23: k = km_ent(1, 2);
      8'h2B: k = km_ent(1, 3);
      8'h34: k = km_ent(1, 4);
      8'h15: k = km_ent(2, 0);
      8'h1D: k = km_ent(2, 1);
      8'h24: k = km_ent(2, 2);
      8'h2D: k = km_ent(2, 3);
      8'h2C: k = km_ent(2, 4);
      8'h16: k = km_ent(3, 0);
      8'h1E: k = km_ent(3, 1);
      8'h26: k = km_ent(3, 2);
      8'h25: k = km_ent(3, 3);
      8'h2E: k = km_ent(3, 4);
      8'h45: k = km_ent(4, 0);
      8'h46: k = km_ent(4, 1);
      8'h3E: k = km_ent(4, 2);
      8'h3D: k = km_ent(4, 3);
      8'h36: k = km_ent(4, 4);
      8'h4D: k = km_ent(5, 0);
      8'h44: k = km_ent(5, 1);
      8'h43: k = km_ent(5, 2);
      8'h3C: k = km_ent(5, 3);
      8'h35: k = km_ent(5, 4);
      8'h5A: k = km_ent(6, 0);
      8'h4B: k = km_ent(6, 1);
      8'h42: k = km_ent(6, 2);
      8'h3B: k = km_ent(6, 3);
      8'h33: k = km_ent(6, 4);
      8'h29: k = km_ent(7, 0);
      8'h59: k = km_ent(7, 1);
      8'h3A: k = km_ent(7, 2);
      8'h31: k = km_ent(7, 3);
      8'h32: k = km_ent(7, 4);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_matrix_kb_keymap.sv
// Scancode to {hit,row,col} lookup; replace this
// module to change the keyboard layout.
import ps2_kb_pkg::*;

module kb_keymap (
  input  logic [7:0] i_code,
  output logic       o_hit,
  output logic [2:0] o_row,
  output logic [2:0] o_col
);

  km_t w_km;

  assign w_km  = zx_keymap(i_code);
  assign o_hit = w_km.hit;
  assign o_row = w_km.row;
  assign o_col = w_km.col;

endmodule

// File: rtl/ps2_matrix_kb.sv
// PS/2 receiver, scancode decoder and key matrix
// with Spectrum-style active-low row/column reads.
import ps2_kb_pkg::*;

module ps2_matrix_kb #(
  parameter int NUM_ROWS       = 8,
  parameter int NUM_COLS       = 5,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk50m,
  input  logic                         reset_n,
  input  logic                         kbd_clk,
  input  logic                         kbd_data,
  input  logic [NUM_ROWS-1:0]          row_sel,
  output logic [NUM_COLS-1:0]          col_n,
  output logic                         key_event,
  output logic [8:0]                   key_code,
  output logic                         key_release,
  output logic                         frame_err,
  output logic [NUM_ROWS*NUM_COLS-1:0] matrix
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NK = NUM_ROWS * NUM_COLS;

  logic [1:0]    r_kclk_sy;
  logic [1:0]    r_kdat_sy;
  logic [FW-1:0] r_fcnt;
  logic          r_kclk_f;
  logic          r_fall;
  logic          r_fdat;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      r_kclk_sy <= '1;
      r_kdat_sy <= '1;
      r_fcnt    <= '0;
      r_kclk_f  <= 1'b1;
      r_fall    <= 1'b0;
      r_fdat    <= 1'b1;
    end else begin
      r_kclk_sy <= {r_kclk_sy[0], kbd_clk};
      r_kdat_sy <= {r_kdat_sy[0], kbd_data};
      r_fall    <= 1'b0;
      if (r_kclk_sy[1] == r_kclk_f) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fcnt   <= '0;
        r_kclk_f <= r_kclk_sy[1];
        r_fall   <= r_kclk_f;
        r_fdat   <= r_kdat_sy[1];
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tocnt;
  logic          r_stb;
  logic [7:0]    r_byte;
  logic          r_rx_err;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tocnt  <= '0;
      r_stb    <= 1'b0;
      r_byte   <= '0;
      r_rx_err <= 1'b0;
    end else begin
      r_stb    <= 1'b0;
      r_rx_err <= 1'b0;
      if (r_fall) begin
        r_tocnt <= '0;
        unique case (1'b1)
          (r_bitcnt == 4'd0): begin
            if (!r_fdat) r_bitcnt <= 4'd1;
          end
          (r_bitcnt inside {[4'd1:4'd8]}): begin
            r_shift  <= {r_fdat, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
          (r_bitcnt == 4'd9): begin
            r_par    <= r_fdat;
            r_bitcnt <= 4'd10;
          end
          default: begin
            r_bitcnt <= '0;
            if (r_fdat && ^{r_shift, r_par}) begin
              r_stb  <= 1'b1;
              r_byte <= r_shift;
            end else begin
              r_rx_err <= 1'b1;
            end
          end
        endcase
      end else if (r_bitcnt == 4'd0) begin
        r_tocnt <= '0;
      end else if (r_tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_tocnt  <= '0;
        r_bitcnt <= '0;
        r_rx_err <= 1'b1;
      end else begin
        r_tocnt <= r_tocnt + 1'b1;
      end
    end
  end

  logic       w_hit;
  logic [2:0] w_row;
  logic [2:0] w_col;

  kb_keymap u_keymap (
    .i_code (r_byte),
    .o_hit  (w_hit),
    .o_row  (w_row),
    .o_col  (w_col)
  );

  dec_state_t r_st;
  dec_state_t w_st_nx;
  logic [2:0] r_skip;
  logic [2:0] w_skip_nx;
  logic       w_emit;
  logic       w_ext;
  logic       w_brk;
  logic       w_clr;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= DEC_IDLE;
      r_skip <= '0;
    end else begin
      r_st   <= w_st_nx;
      r_skip <= w_skip_nx;
    end
  end

  always_comb begin
    w_st_nx   = r_st;
    w_skip_nx = r_skip;
    w_emit    = 1'b0;
    w_ext     = 1'b0;
    w_brk     = 1'b0;
    w_clr     = 1'b0;
    if (r_stb) begin
      unique case (r_st)
        DEC_IDLE: begin
          unique case (1'b1)
            (r_byte == PS2_E0): w_st_nx = DEC_EXT;
            (r_byte == PS2_F0): w_st_nx = DEC_BRK;
            (r_byte == PS2_E1): begin
              w_st_nx   = DEC_PAUSE;
              w_skip_nx = 3'(PAUSE_SKIP);
            end
            is_clear(r_byte): w_clr = 1'b1;
            default: w_emit = 1'b1;
          endcase
        end
        DEC_EXT: begin
          if (r_byte == PS2_F0) begin
            w_st_nx = DEC_EXT_BRK;
          end else begin
            w_emit  = 1'b1;
            w_ext   = 1'b1;
            w_st_nx = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          w_emit  = 1'b1;
          w_brk   = 1'b1;
          w_st_nx = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          w_emit  = 1'b1;
          w_ext   = 1'b1;
          w_brk   = 1'b1;
          w_st_nx = DEC_IDLE;
        end
        DEC_PAUSE: begin
          w_skip_nx = r_skip - 3'd1;
          if (r_skip == 3'd1) w_st_nx = DEC_IDLE;
        end
        default: w_st_nx = DEC_IDLE;
      endcase
    end
  end

  logic [NK-1:0] r_matrix;
  logic [NK-1:0] w_mat_nx;

  always_comb begin
    w_mat_nx = r_matrix;
    if (w_clr) begin
      w_mat_nx = '0;
    end else if (w_emit && w_hit) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (int'(w_row) == r && int'(w_col) == c)
            w_mat_nx[r*NUM_COLS+c] = !w_brk;
        end
      end
    end
  end

  logic       r_key_event;
  logic [8:0] r_key_code;
  logic       r_key_release;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      r_matrix      <= '0;
      r_key_event   <= 1'b0;
      r_key_code    <= '0;
      r_key_release <= 1'b0;
    end else begin
      r_matrix    <= w_mat_nx;
      r_key_event <= w_emit;
      if (w_emit) begin
        r_key_code    <= {w_ext, r_byte};
        r_key_release <= w_brk;
      end
    end
  end

  logic [NUM_COLS-1:0] w_col_n;

  always_comb begin
    w_col_n = '1;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!row_sel[r] && r_matrix[r*NUM_COLS+c])
          w_col_n[c] = 1'b0;
      end
    end
  end

  assign col_n       = w_col_n;
  assign matrix      = r_matrix;
  assign key_event   = r_key_event;
  assign key_code    = r_key_code;
  assign key_release = r_key_release;
  assign frame_err   = r_rx_err;

endmodule
